regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single write port of the 8x16 register file between two requesters (REQ0, REQ1).
//  - Each requester has a valid/ready handshake and a 1-entry input buffer.
//  - Buffered writes go through a 2-way round-robin arbiter.
//  - The winner is registered onto wr_en/write_reg/write_data, which connect directly to the register file.
//  - The register file commits on negedge clk, so a write issued at posedge N is visible by posedge N+1.
// PARAMETERS
//  AW   3   register address width (8 registers)
//  DW   16  register data width
// PORTS
//  clk          in   1     clock; all state updates on posedge
//  rst          in   1     asynchronous reset, active-high
//  req_valid    in   2     per-requester write request valid, [i] = REQi
//  req_ready    out  2     per-requester buffer can accept
//  req_addr0    in   AW    REQ0 target register
//  req_data0    in   DW    REQ0 write data
//  req_addr1    in   AW    REQ1 target register
//  req_data1    in   DW    REQ1 write data
//  done         out  2     one-cycle pulse: REQi write is on the port this cycle
//  wr_en        out  1     register file write enable
//  write_reg    out  AW    register file write address
//  write_data   out  DW    register file write data
//  pending      out  2     REQi buffer occupied
// BEHAVIOUR
//  Reset (async, rst=1): all outputs and state are cleared.
//   - buffers empty, so pending=0 and req_ready=2'b11.
//   - wr_en=0, write_reg=0, write_data=0, done=0.
//   - rr pointer=0, so REQ0 has priority.
//   - Reset mid-operation drops buffered requests. No write is issued after rst deasserts.
//  Handshake:
//   - Accept REQi at posedge when req_valid[i] & req_ready[i]; capture addr/data into buf i.
//   - req_ready[i] = ~buf_valid[i] | grant[i]. A granted buffer may be refilled in the same cycle.
//   - req_addr/req_data are sampled only on acceptance.
//  Arbitration (combinational, each cycle):
//   - Only buf0 valid -> grant0. Only buf1 valid -> grant1. Neither -> no grant.
//   - Both valid -> grant the requester the rr pointer favours.
//   - After any grant, the pointer moves to favour the other requester.
//  Output stage (registered):
//   - At posedge with grant[i]: wr_en<=1, write_reg<=buf_addr_i, write_data<=buf_data_i, done<=onehot(i); clear buf i.
//   - Without a grant: wr_en<=0, done<=0. write_reg/write_data hold their last values.
//  Timing:
//   - Latency from acceptance (posedge N) to wr_en high is 1 cycle (posedge N+1) when uncontended.
//   - Under contention the loser waits exactly one extra cycle.
//   - Throughput is one write per cycle. Sustained dual traffic alternates 0,1,0,1.
//  Boundary conditions:
//   - Simultaneous accept and grant on the same buffer: the new entry is held, the old one is issued.
//   - Both requesters target the same register: two separate writes in rr order; the last written value persists.
//   - req_valid held with ready=0: the request stays pending and is not duplicated.
// CONFIGURATION
//  Macro REGFILE_ARB_MERGE_EN.
//  Defined: when both buffers are valid with equal addresses, only the rr winner's data is written.
//   - Both buffers clear in the same cycle.
//   - done=2'b11 for that cycle.
//   - The rr pointer moves as after a normal grant.
//  Undefined: same-address writes are serialised as described above, and done is always one-hot or zero.
// STRUCTURE
//  Package regfile_arb_pkg:
//   - REG_AW=3, REG_DW=16, NUM_REQ=2.
//   - Requester index constants REQ0=0, REQ1=1.
//  Sub-module rr_arb2:
//   - Inputs: clk, rst, req[1:0], adv.
//   - Output: gnt[1:0].
//   - Owns the rr pointer register.
//  Buffers, handshake and the output stage stay in the top module.
// TESTING
//  1. Reset: rst=1 mid-traffic -> wr_en=0, done=0, pending=0, req_ready=11; nothing written after release.
//  2. Single write: REQ0 addr=3 data=16'hABCD at posedge N -> posedge N+1: wr_en=1, write_reg=3, write_data=ABCD, done=01; mem[3] reads ABCD next cycle.
//  3. Contention: both valid in the same cycle, REQ0 a=1 d=1111, REQ1 a=2 d=2222, pointer=0 -> REQ0 written first, then REQ1, done=01 then 10.
//  4. Back-to-back: both hold valid for 6 cycles -> grants alternate 0,1,0,1,...; wr_en stays high; no lost or duplicated writes (scoreboard).
//  5. Same address: both target reg 5 (d=AAAA / 5555), pointer=1 -> without the macro, 5555 then AAAA, final AAAA; with REGFILE_ARB_MERGE_EN, a single write of 5555 and done=11.
//  6. Refill: REQ1 presents a new request in the grant cycle -> req_ready[1]=1, accepted, issued the next cycle; pending[1] stays 1.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_arb_pkg;

  localparam int REG_AW  = 3;
  localparam int REG_DW  = 16;
  localparam int NUM_REQ = 2;
  localparam int REQ0    = 0;
  localparam int REQ1    = 1;

  typedef enum logic {
    FAV_REQ0 = 1'b0,
    FAV_REQ1 = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester handshakes plus register-file write port of regfile_wr_arbiter.
interface regfile_wr_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
);

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [AW-1:0]      req_addr0;
  logic [DW-1:0]      req_data0;
  logic [AW-1:0]      req_addr1;
  logic [DW-1:0]      req_data1;
  logic [NUM_REQ-1:0] done;
  logic               wr_en;
  logic [AW-1:0]      write_reg;
  logic [DW-1:0]      write_data;
  logic [NUM_REQ-1:0] pending;

  modport master (
    output req_valid, req_addr0, req_data0, req_addr1, req_data1,
    input  req_ready, done, wr_en, write_reg, write_data, pending
  );

  modport slave (
    input  req_valid, req_addr0, req_data0, req_addr1, req_data1,
    output req_ready, done, wr_en, write_reg, write_data, pending
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; owns the pointer that says which requester wins a tie.
module rr_arb2
  import regfile_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt
);

  rr_ptr_e ptr_q;
  rr_ptr_e ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= FAV_REQ0;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    if (req[REQ0] && (!req[REQ1] || ptr_q == FAV_REQ0)) gnt[REQ0] = 1'b1;
    else if (req[REQ1])                                 gnt[REQ1] = 1'b1;
    // The pointer always ends up favouring whoever did not just win.
    if (adv && gnt[REQ0])      ptr_d = FAV_REQ1;
    else if (adv && gnt[REQ1]) ptr_d = FAV_REQ0;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between two buffered requesters.
// Optional REGFILE_ARB_MERGE_EN: same-address pending writes collapse into one.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
)(
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
);

  logic [NUM_REQ-1:0] buf_vld_q, buf_vld_d;
  logic [AW-1:0]      buf_addr_q [NUM_REQ];
  logic [AW-1:0]      buf_addr_d [NUM_REQ];
  logic [DW-1:0]      buf_data_q [NUM_REQ];
  logic [DW-1:0]      buf_data_d [NUM_REQ];
  logic               wr_en_q, wr_en_d;
  logic [AW-1:0]      write_reg_q, write_reg_d;
  logic [DW-1:0]      write_data_q, write_data_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] clr;
  logic [NUM_REQ-1:0] rdy;
  logic [NUM_REQ-1:0] acc;
  logic               merge;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (buf_vld_q),
    .adv (|gnt),
    .gnt (gnt)
  );

  always_comb begin
    merge = 1'b0;
`ifdef REGFILE_ARB_MERGE_EN
    merge = (&buf_vld_q) && (buf_addr_q[REQ0] == buf_addr_q[REQ1]);
`endif
    // A merged write retires the losing buffer together with the winner.
    clr       = merge ? {NUM_REQ{1'b1}} : gnt;
    rdy       = ~buf_vld_q | clr;
    acc       = bus.req_valid & rdy;
    buf_vld_d = acc | (buf_vld_q & ~clr);

    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    if (acc[REQ0]) begin
      buf_addr_d[REQ0] = bus.req_addr0;
      buf_data_d[REQ0] = bus.req_data0;
    end
    if (acc[REQ1]) begin
      buf_addr_d[REQ1] = bus.req_addr1;
      buf_data_d[REQ1] = bus.req_data1;
    end

    wr_en_d      = |gnt;
    done_d       = clr;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (gnt[REQ0]) begin
      write_reg_d  = buf_addr_q[REQ0];
      write_data_d = buf_data_q[REQ0];
    end else if (gnt[REQ1]) begin
      write_reg_d  = buf_addr_q[REQ1];
      write_data_d = buf_data_q[REQ1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld_q    <= '0;
      buf_addr_q   <= '{default: '0};
      buf_data_q   <= '{default: '0};
      wr_en_q      <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      done_q       <= '0;
    end else begin
      buf_vld_q    <= buf_vld_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      wr_en_q      <= wr_en_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      done_q       <= done_d;
    end
  end

  assign bus.req_ready  = rdy;
  assign bus.pending    = buf_vld_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a queue-based write scoreboard.
module tb_regfile_wr_arbiter;

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
    logic [1:0]  dn;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q [$];
  logic [15:0] mem [8];

  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.AW(3), .DW(16)) ifc ();

  regfile_wr_arbiter #(.AW(3), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial for (int i = 0; i < 8; i++) mem[i] = 16'h0;

  // Register file model: commits on the falling edge.
  always @(negedge clk) if (ifc.wr_en) mem[ifc.write_reg] <= ifc.write_data;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.wr_en) begin
        wr_t got;
        wr_t want;
        got = '{a: ifc.write_reg, d: ifc.write_data, dn: ifc.done};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got reg=%0d data=%h done=%b, required none", got.a, got.d, got.dn);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL write got reg=%0d data=%h done=%b, required reg=%0d data=%h done=%b",
                     got.a, got.d, got.dn, want.a, want.d, want.dn);
          end
        end
      end else if (ifc.done !== 2'b00) begin
        checks++;
        errors++;
        $display("FAIL done_without_wr_en got done=%b, required 00", ifc.done);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [2:0] a0, input logic [15:0] d0,
                       input logic [2:0] a1, input logic [15:0] d1, output logic [1:0] acc);
    ifc.req_valid = v;
    ifc.req_addr0 = a0;
    ifc.req_data0 = d0;
    ifc.req_addr1 = a1;
    ifc.req_data1 = d1;
    #1;
    acc = v & ifc.req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic [1:0] acc;
    for (int i = 0; i < n; i++) drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, acc);
  endtask

  initial begin
    logic [1:0] acc;
    int c0;
    int c1;
    ifc.req_valid = 2'b00;
    ifc.req_addr0 = 3'd0;
    ifc.req_data0 = 16'h0;
    ifc.req_addr1 = 3'd0;
    ifc.req_data1 = 16'h0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en",     32'(ifc.wr_en),      32'h0);
    check("rst_done",      32'(ifc.done),       32'h0);
    check("rst_pending",   32'(ifc.pending),    32'h0);
    check("rst_req_ready", 32'(ifc.req_ready),  32'h3);
    check("rst_write_reg", 32'(ifc.write_reg),  32'h0);
    check("rst_write_dat", 32'(ifc.write_data), 32'h0);
    rst = 1'b0;
    idle(1);

    // Single write
    exp_q.push_back('{a: 3'd3, d: 16'hABCD, dn: 2'b01});
    drive(2'b01, 3'd3, 16'hABCD, 3'd0, 16'h0, acc);
    check("t2_accept",  32'(acc),         32'h1);
    check("t2_pending", 32'(ifc.pending), 32'h1);
    idle(1);
    check("t2_wr_en",      32'(ifc.wr_en),      32'h1);
    check("t2_write_reg",  32'(ifc.write_reg),  32'h3);
    check("t2_write_data", 32'(ifc.write_data), 32'hABCD);
    check("t2_done",       32'(ifc.done),       32'h1);
    idle(1);
    check("t2_mem3", 32'(mem[3]), 32'hABCD);
    check("t2_wr_en_off", 32'(ifc.wr_en), 32'h0);

    // Reset mid-traffic: buffered requests are dropped
    drive(2'b11, 3'd1, 16'hDEAD, 3'd2, 16'hBEEF, acc);
    check("t1_pending_pre", 32'(ifc.pending), 32'h3);
    #2 rst = 1'b1;
    #1;
    check("t1_wr_en",      32'(ifc.wr_en),     32'h0);
    check("t1_done",       32'(ifc.done),      32'h0);
    check("t1_pending",    32'(ifc.pending),   32'h0);
    check("t1_req_ready",  32'(ifc.req_ready), 32'h3);
    check("t1_write_reg",  32'(ifc.write_reg), 32'h0);
    ifc.req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(4);
    check("t1_mem1", 32'(mem[1]), 32'h0);
    check("t1_mem2", 32'(mem[2]), 32'h0);

    // Contention, pointer favours REQ0
    exp_q.push_back('{a: 3'd1, d: 16'h1111, dn: 2'b01});
    exp_q.push_back('{a: 3'd2, d: 16'h2222, dn: 2'b10});
    drive(2'b11, 3'd1, 16'h1111, 3'd2, 16'h2222, acc);
    check("t3_accept", 32'(acc), 32'h3);
    idle(1);
    check("t3_done0", 32'(ifc.done), 32'h1);
    idle(1);
    check("t3_done1", 32'(ifc.done), 32'h2);
    idle(2);
    check("t3_mem1", 32'(mem[1]), 32'h1111);
    check("t3_mem2", 32'(mem[2]), 32'h2222);

    // Back-to-back dual traffic: A0 B0 A1 B1 A2 B2 A3
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{a: 3'(k),     d: 16'hA000 + 16'(k), dn: 2'b01});
      exp_q.push_back('{a: 3'(4 + k), d: 16'hB000 + 16'(k), dn: 2'b10});
    end
    exp_q.push_back('{a: 3'd3, d: 16'hA003, dn: 2'b01});
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, 3'(c0), 16'hA000 + 16'(c0), 3'(4 + c1), 16'hB000 + 16'(c1), acc);
      if (acc[0]) c0++;
      if (acc[1]) c1++;
      if (k >= 1) check("t4_wr_en", 32'(ifc.wr_en), 32'h1);
    end
    check("t4_acc0", c0, 4);
    check("t4_acc1", c1, 3);
    idle(1);
    check("t4_tail_done_b2", 32'(ifc.done), 32'h2);
    idle(1);
    check("t4_tail_done_a3", 32'(ifc.done), 32'h1);
    idle(2);

    // Same address, pointer favours REQ1
`ifdef REGFILE_ARB_MERGE_EN
    exp_q.push_back('{a: 3'd5, d: 16'h5555, dn: 2'b11});
`else
    exp_q.push_back('{a: 3'd5, d: 16'h5555, dn: 2'b10});
    exp_q.push_back('{a: 3'd5, d: 16'hAAAA, dn: 2'b01});
`endif
    drive(2'b11, 3'd5, 16'hAAAA, 3'd5, 16'h5555, acc);
    idle(4);
`ifdef REGFILE_ARB_MERGE_EN
    check("t5_mem5", 32'(mem[5]), 32'h5555);
`else
    check("t5_mem5", 32'(mem[5]), 32'hAAAA);
`endif

    // Refill REQ1 in its grant cycle
    exp_q.push_back('{a: 3'd6, d: 16'h6666, dn: 2'b10});
    exp_q.push_back('{a: 3'd7, d: 16'h7777, dn: 2'b10});
    drive(2'b10, 3'd0, 16'h0, 3'd6, 16'h6666, acc);
    check("t6_accept_first", 32'(acc), 32'h2);
    drive(2'b10, 3'd0, 16'h0, 3'd7, 16'h7777, acc);
    check("t6_refill_ready", 32'(acc), 32'h2);
    check("t6_pending_held", 32'(ifc.pending), 32'h2);
    check("t6_done_first",   32'(ifc.done),    32'h2);
    idle(1);
    check("t6_write_second", 32'(ifc.write_data), 32'h7777);
    check("t6_pending_empty", 32'(ifc.pending), 32'h0);
    idle(2);
    check("t6_mem7", 32'(mem[7]), 32'h7777);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
